// File: rtl/rotate_seq_pkg.sv
// Shared types and constants for the iterative rotate sequencer.
package rotate_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } rotate_seq_state_t;

  localparam logic ROT_LEFT  = 1'b0;
  localparam logic ROT_RIGHT = 1'b1;

endpackage

// File: rtl/rotate_sequencer_fixed_rotate.sv
// Combinational circular rotate of an N-bit word by the constant S in direction DIR.
module fixed_rotate
  import rotate_seq_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned S   = 1,
  parameter logic        DIR = ROT_LEFT
) (
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  generate
    if (DIR == ROT_LEFT) begin : g_left
      assign q_o = {d_i[N-1-S:0], d_i[N-1:N-S]};
    end else begin : g_right
      assign q_o = {d_i[S-1:0], d_i[N-1:S]};
    end
  endgenerate

endmodule

// File: rtl/rotate_sequencer.sv
// Valid/ready rotate controller: applies one 2^k rotate stage per cycle, LSB of amount first.
module rotate_sequencer
  import rotate_seq_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [W-1:0] in_amt,
  input  logic         in_dir,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);

  localparam logic [W-1:0] K_LAST = W'(W - 1);

  rotate_seq_state_t state_q, state_d;
  logic [W-1:0]      k_q, k_d;
  logic [W-1:0]      amt_q, amt_d;
  logic              dir_q, dir_d;
  logic [N-1:0]      work_q, work_d;

  logic [N-1:0]      cand [W];
  logic [N-1:0]      step_word;
  logic [W-1:0]      amt_sh;
  logic              step_bit;

  // One left and one right stage per amount bit; only the stage matching k contributes.
  for (genvar g = 0; g < W; g++) begin : g_stage
    localparam logic [W-1:0] KG = W'(g);
    logic [N-1:0] rot_l, rot_r;

    fixed_rotate #(.N(N), .S(1 << g), .DIR(ROT_LEFT)) u_rot_l (
      .d_i(work_q),
      .q_o(rot_l)
    );

    fixed_rotate #(.N(N), .S(1 << g), .DIR(ROT_RIGHT)) u_rot_r (
      .d_i(work_q),
      .q_o(rot_r)
    );

    assign cand[g] = (k_q != KG)         ? '0    :
                     (dir_q == ROT_RIGHT) ? rot_r : rot_l;
  end

  always_comb begin
    step_word = '0;
    for (int unsigned j = 0; j < W; j++) begin
      step_word = step_word | cand[j];
    end
  end

  assign amt_sh   = amt_q >> k_q;
  assign step_bit = amt_sh[0];

  // Handshake outputs are forced low during reset so an aborted result is never offered.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE) && !rst;
  assign out_data  = work_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    amt_d   = amt_q;
    dir_d   = dir_q;
    work_d  = work_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          amt_d   = in_amt;
          dir_d   = in_dir;
          k_d     = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (step_bit) begin
          work_d = step_word;
        end
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      amt_q   <= '0;
      dir_q   <= ROT_LEFT;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      amt_q   <= amt_d;
      dir_q   <= dir_d;
      work_q  <= work_d;
    end
  end

endmodule

// File: tb/tb_rotate_sequencer.sv
// Self-checking bench for rotate_sequencer (N=8): transaction-level model plus directed literal checks.
module tb_rotate_sequencer;

  localparam int N   = 8;
  localparam int W   = 3;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [W-1:0] in_amt;
  logic         in_dir;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    logic [N-1:0] exp;
    int           acc;
  } txn_t;
  txn_t q[$];

  rotate_sequencer #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Reference: left moves bit i to (i+s) mod N, right moves it to (i-s) mod N.
  function automatic logic [N-1:0] ref_rot(input logic [N-1:0] d, input int s, input logic r);
    logic [N-1:0] o;
    o = '0;
    for (int i = 0; i < N; i++) begin
      if (r) o[(i - s + N) % N] = d[i];
      else   o[(i + s) % N]     = d[i];
    end
    return o;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: one request in flight, result offered LAT cycles after accept.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
    end else if (q.size() > 0) begin
      if (cyc >= q[0].acc + LAT && out_ready) void'(q.pop_front());
    end else if (in_valid) begin
      q.push_back('{exp: ref_rot(in_data, int'(in_amt), in_dir), acc: cyc});
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic ir_e, ov_e;
    ir_e = !rst && (q.size() == 0);
    ov_e = !rst && (q.size() > 0) && (cyc >= q[0].acc + LAT);
    check("in_ready", 32'(in_ready), 32'(ir_e));
    check("out_valid", 32'(out_valid), 32'(ov_e));
    if (ov_e) check("out_data", 32'(out_data), 32'(q[0].exp));
  end

  task automatic send(input logic [N-1:0] d, input logic [W-1:0] a, input logic r);
    bit acc;
    int n;
    in_valid = 1'b1; in_data = d; in_amt = a; in_dir = r;
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      miscompares++;
      $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
    end
    in_valid = 1'b0;
    in_data = '0; in_amt = '0; in_dir = 1'b0;
  endtask

  // Returns number of negedges after the accept edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 30);
    if (!out_valid) begin
      miscompares++;
      $display("FAIL valid_timeout: got out_valid=0 expected 1 within 30 cycles");
    end
  endtask

  task automatic directed(input string nm, input logic [N-1:0] d, input logic [W-1:0] a,
                          input logic r, input logic [N-1:0] exp);
    int lat;
    send(d, a, r);
    wait_valid(lat);
    check({nm, "_lat"}, 32'(lat), 32'(LAT));
    check({nm, "_data"}, 32'(out_data), 32'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_dir = 1'b0; out_ready = 1'b1;
    check("pin_left3", 32'(ref_rot(8'hA1, 3, 1'b0)), 32'h0D);
    check("pin_right3", 32'(ref_rot(8'hA1, 3, 1'b1)), 32'h34);
    check("pin_right1", 32'(ref_rot(8'h3C, 1, 1'b1)), 32'h1E);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;

    directed("left3",  8'hA1, 3'd3, 1'b0, 8'h0D);
    directed("right3", 8'hA1, 3'd3, 1'b1, 8'h34);
    directed("left0",  8'hA1, 3'd0, 1'b0, 8'hA1);
    directed("right0", 8'hA1, 3'd0, 1'b1, 8'hA1);
    directed("left7",  8'h81, 3'd7, 1'b0, 8'hC0);

    // Backpressure: result held, second request waits for the IDLE cycle.
    out_ready = 1'b0;
    send(8'hA1, 3'd3, 1'b0);
    wait_valid(lat);
    in_valid = 1'b1; in_data = 8'h3C; in_amt = 3'd1; in_dir = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'h0D);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_second_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_second_lat", 32'(lat), 32'(LAT));
    check("bp_second_data", 32'(out_data), 32'h1E);
    @(posedge clk); #1;

    // Reset during BUSY step 1 aborts the request.
    send(8'hA1, 3'd5, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    directed("after_abort", 8'h81, 3'd7, 1'b0, 8'hC0);

    // Exhaustive sweep; the per-cycle model compare does the checking.
    for (int d = 0; d < 256; d++) begin
      for (int a = 0; a < N; a++) begin
        for (int r = 0; r < 2; r++) begin
          send(8'(d), 3'(a), 1'(r));
        end
      end
    end
    repeat (LAT + 3) @(posedge clk);
    #1;
    check("final_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
